rst_mgr: RTL
============

# rst_mgr

Reset manager that sits directly upstream of the system core on the FPGA board top level. It synchronizes and debounces the raw reset pushbutton, and stretches every reset request into a fixed-length synchronous reset pulse on `sys_rst_o`, which drives the system's `reset` input. It also records the cause of the last reset. An optional watchdog can force a reset.

## Interface
- `HOLD_CYCLES`, 65535: length of every `sys_rst_o` pulse, in clk cycles; must be at least 2.
- `DB_CYCLES`, 50000: consecutive stable cycles required for a button level change to be accepted; must be at least 2.
- `WDOG_CYCLES`, 2^24: watchdog timeout in clk cycles; only used with `RST_MGR_WDOG_EN`.
- `clk`  in  1  system clock.
- `reset`  in  1  board-level power-on reset; asynchronous, active-high.
- `btn_i`  in  1  raw pushbutton level, asynchronous to clk, active-high.
- `wdog_en_i`  in  1  watchdog enable, synchronous to clk.
- `wdog_kick_i`  in  1  single-cycle watchdog refresh, synchronous to clk.
- `sys_rst_o`  out  1  synchronous active-high reset to the system.
- `rst_cause_o`  out  2  cause of the last reset: 00 power-on, 01 button, 10 watchdog, 11 never produced.

## Operation
- Button input path: `btn_i` goes through a 2-flop synchronizer, giving `btn_s`. A debounce counter clears whenever `btn_s` equals the debounced level `btn_db`, and increments otherwise. When the counter reaches `DB_CYCLES-1` while `btn_s` still differs, `btn_db` takes the value of `btn_s` and the counter clears.
- The FSM has three states: HOLD, RUN, WAIT_REL.
- HOLD:
  - `sys_rst_o` is 1.
  - `hold_cnt` is loaded with `HOLD_CYCLES-1` on entry and decrements every cycle.
  - When `hold_cnt` is 0: go to RUN if `btn_db` is 0, otherwise go to WAIT_REL.
- RUN:
  - `sys_rst_o` is 0.
  - A rising edge of `btn_db` moves the FSM to WAIT_REL and sets `rst_cause_o` to 01.
  - Watchdog expiry moves the FSM to HOLD and sets `rst_cause_o` to 10.
- WAIT_REL:
  - `sys_rst_o` is 1.
  - When `btn_db` is 0, go to HOLD and reload `hold_cnt`.
- `sys_rst_o` is a register equal to (next_state != RUN). It is glitch-free and changes only on clk edges.
- `rst_cause_o` changes only on entry into a reset sequence, and holds its value until the next cause.
- Reset values while `reset` is asserted:
  - state HOLD, `hold_cnt` = `HOLD_CYCLES-1`
  - `sys_rst_o` = 1, `rst_cause_o` = 00
  - synchronizer flops, `btn_db` and debounce counter all 0
  - watchdog counter 0
- Simultaneous events in RUN:
  - Button rise and watchdog expiry in the same cycle: the button wins (WAIT_REL, cause 01).
- Button events outside RUN:
  - A button press during HOLD is not lost. HOLD completes, then the FSM enters WAIT_REL because `btn_db` is 1, and `rst_cause_o` is unchanged.
  - Button bounces shorter than `DB_CYCLES` have no effect.
- `reset` asserted at any point returns all state to the reset values immediately, whatever the current state or counter values.

## Timing
- After `reset` deasserts, `sys_rst_o` stays 1 for exactly `HOLD_CYCLES` rising clk edges and falls on edge number `HOLD_CYCLES`.
- Button assertion latency: if `btn_i` rises and is first sampled high at edge N, then:
  - `btn_db` rises at edge N+1+`DB_CYCLES`
  - `sys_rst_o` rises at edge N+2+`DB_CYCLES`
- Button release: release is debounced with the same latency. `sys_rst_o` then stays high for a further `HOLD_CYCLES` cycles after HOLD is entered.
- Counter widths are $clog2 of their terminal counts; no counter wraps.

## Configuration
- Macro: `RST_MGR_WDOG_EN`.
- Defined:
  - The watchdog counter runs only in RUN while `wdog_en_i` is 1, and clears in any other state or when `wdog_en_i` is 0.
  - `wdog_kick_i` clears the counter.
  - The counter expires when it reaches `WDOG_CYCLES-1` with no kick in that cycle; a kick in the same cycle as expiry wins.
  - After an expiry reset, the counter restarts from 0 on entry to RUN.
- Undefined: `wdog_en_i` and `wdog_kick_i` remain as ports but are ignored, there is no watchdog logic, and `rst_cause_o` never reports 10.

## Test plan
All scenarios use `HOLD_CYCLES`=8, `DB_CYCLES`=4, `WDOG_CYCLES`=20.
- Power-on: assert `reset` mid-cycle, release it, hold `btn_i` at 0 -> `sys_rst_o` is 1 for 8 edges and then 0, `rst_cause_o` = 00.
- Bounce rejection: in RUN, pulse `btn_i` high for 3 cycles, repeated 5 times with 2-cycle gaps -> `sys_rst_o` stays 0, `rst_cause_o` stays 00.
- Button reset: in RUN, hold `btn_i` high for 30 cycles and then release -> `sys_rst_o` rises 6 edges after first sample, stays high through release debounce plus 8 HOLD cycles, and `rst_cause_o` = 01.
- Press during HOLD: assert `btn_i` 2 cycles after `reset` release and hold it for 20 cycles -> `sys_rst_o` stays high continuously until release debounce plus 8 cycles, and `rst_cause_o` = 00.
- Watchdog (macro on): `wdog_en_i` = 1, no kicks -> `sys_rst_o` rises 20 cycles after entering RUN, `rst_cause_o` = 10. A kick every 15 cycles -> no reset. A kick on the expiry cycle -> no reset.
- Async reset mid-operation: assert `reset` during WAIT_REL -> `sys_rst_o` = 1, `rst_cause_o` = 00 and the state is HOLD immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/rst_mgr.sv
`default_nettype none
// ============================================================================
// Module   : rst_mgr
// Purpose  : Button synchronizer/debouncer, stretched system reset pulse,
//            reset-cause tracking. Optional watchdog via RST_MGR_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rst_mgr #(
    parameter int HOLD_CYCLES = 65535,
    parameter int DB_CYCLES   = 50000,
    parameter int WDOG_CYCLES = 1 << 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_i,
    input  logic       wdog_en_i,
    input  logic       wdog_kick_i,
    output logic       sys_rst_o,
    output logic [1:0] rst_cause_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int DB_W   = $clog2(DB_CYCLES);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

    localparam logic [1:0] HOLD     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

    logic              btn_meta;
    logic              btn_s;
    logic              btn_db;
    logic [DB_W-1:0]   db_cnt;
    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              wdog_expire;
    logic              sys_rst_nxt;
    logic [1:0]        cause_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_meta <= btn_i;
            btn_s    <= btn_meta;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

`ifdef RST_MGR_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_run;

    assign wdog_run    = (state == RUN) && wdog_en_i;
    // A kick on the terminal cycle suppresses expiry.
    assign wdog_expire = wdog_run && !wdog_kick_i && (wdog_cnt == WDOG_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if (!wdog_run || wdog_kick_i || wdog_expire) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end
`else
    logic unused_wdog;

    assign wdog_expire = 1'b0;
    assign unused_wdog = wdog_en_i ^ wdog_kick_i ^ (WDOG_CYCLES == 0);
`endif

    // Held at the load value outside HOLD so every entry starts a full pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= HOLD_LOAD;
        end else if (state != HOLD) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HOLD;
            sys_rst_o   <= 1'b1;
            rst_cause_o <= CAUSE_POR;
        end else begin
            state       <= next_state;
            sys_rst_o   <= sys_rst_nxt;
            rst_cause_o <= cause_nxt;
        end
    end

    // In RUN btn_db can only be high after a fresh rise, since HOLD exits to
    // WAIT_REL whenever the button is still pressed.
    always_comb begin
        next_state = state;
        case (state)
            HOLD: begin
                if (hold_cnt == '0) begin
                    next_state = btn_db ? WAIT_REL : RUN;
                end
            end
            RUN: begin
                if (btn_db) begin
                    next_state = WAIT_REL;
                end else if (wdog_expire) begin
                    next_state = HOLD;
                end
            end
            WAIT_REL: begin
                if (!btn_db) begin
                    next_state = HOLD;
                end
            end
            default: next_state = HOLD;
        endcase
    end

    always_comb begin
        sys_rst_nxt = (next_state != RUN);
        cause_nxt   = rst_cause_o;
        if (state == RUN) begin
            if (btn_db) begin
                cause_nxt = CAUSE_BTN;
            end else if (wdog_expire) begin
                cause_nxt = CAUSE_WDOG;
            end
        end
    end

endmodule
`default_nettype wire
